// File: rtl/mem_arbiter_if.sv
// Cache/memory side signals of the refill arbiter, bundled so the arbiter sees one port.
// master = arbiter view; slave = caches plus memory.
interface mem_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int LINE_WORDS = 4
);
    localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic             ic_req;
    logic [WIDTH-1:0] ic_addr;
    logic             dc_req;
    logic             dc_dirty;
    logic [WIDTH-1:0] dc_wb_addr;
    logic [WIDTH-1:0] dc_addr;
    logic [WIDTH-1:0] dc_wdata;
    logic             ic_rvalid;
    logic             dc_rvalid;
    logic [WIDTH-1:0] rdata;
    logic [BW-1:0]    beat;
    logic             ic_done;
    logic             dc_done;
    logic             busy;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        input  ic_req, ic_addr, dc_req, dc_dirty, dc_wb_addr, dc_addr, dc_wdata,
               mem_ready, mem_rdata,
        output ic_rvalid, dc_rvalid, rdata, beat, ic_done, dc_done, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_dirty, dc_wb_addr, dc_addr, dc_wdata,
               mem_ready, mem_rdata,
        input  ic_rvalid, dc_rvalid, rdata, beat, ic_done, dc_done, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache refill and D-cache write-back + refill; MEM_ARB_RR_EN selects round-robin.
// Latency: grant cycle, then LINE_WORDS beats (2x when dirty), then a one-cycle done pulse.
// Backpressure: each beat holds address/data until mem_ready; requests wait in IDLE until granted.
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [WIDTH-1:0] OFF_MASK = WIDTH'(LINE_WORDS * 4 - 1);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        IC_FILL,
        DC_WB,
        DC_FILL,
        DONE_IC,
        DONE_DC
    } state_t;

    state_t           state, state_nxt;
    logic [BW-1:0]    beat_q;
    logic [WIDTH-1:0] wb_base, fill_base, cur_base;
    logic             grant_ic, grant_dc;
    logic             active, last_beat, beat_done;

`ifdef MEM_ARB_RR_EN
    logic             last_grant_dc;
`endif

    assign active    = (state == IC_FILL) || (state == DC_WB) || (state == DC_FILL);
    assign last_beat = (beat_q == LAST_BEAT);
    assign beat_done = active && bus.mem_ready;

    always_comb begin
        state_nxt = state;
        grant_ic  = 1'b0;
        grant_dc  = 1'b0;
        case (state)
            IDLE: begin
`ifdef MEM_ARB_RR_EN
                if (bus.dc_req && bus.ic_req) begin
                    grant_dc = !last_grant_dc;
                    grant_ic = last_grant_dc;
                end else begin
                    grant_dc = bus.dc_req;
                    grant_ic = bus.ic_req;
                end
`else
                grant_dc = bus.dc_req;
                grant_ic = bus.ic_req && !bus.dc_req;
`endif
                if (grant_dc)
                    state_nxt = bus.dc_dirty ? DC_WB : DC_FILL;
                else if (grant_ic)
                    state_nxt = IC_FILL;
            end
            IC_FILL: if (beat_done && last_beat) state_nxt = DONE_IC;
            DC_WB:   if (beat_done && last_beat) state_nxt = DC_FILL;
            DC_FILL: if (beat_done && last_beat) state_nxt = DONE_DC;
            DONE_IC: state_nxt = IDLE;
            DONE_DC: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_q    <= '0;
            wb_base   <= '0;
            fill_base <= '0;
        end else begin
            state <= state_nxt;
            // Wrapping to 0 on the last write-back beat starts the fill at beat 0.
            if (beat_done)
                beat_q <= last_beat ? '0 : beat_q + BW'(1);
            if (grant_dc) begin
                wb_base   <= bus.dc_wb_addr & ~OFF_MASK;
                fill_base <= bus.dc_addr & ~OFF_MASK;
            end else if (grant_ic) begin
                fill_base <= bus.ic_addr & ~OFF_MASK;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant_dc <= 1'b0;
        else if (grant_dc)
            last_grant_dc <= 1'b1;
        else if (grant_ic)
            last_grant_dc <= 1'b0;
    end
`endif

    assign cur_base = (state == DC_WB) ? wb_base : fill_base;

    // Every output is gated by state so IDLE (and reset) drives all zeros.
    assign bus.mem_req   = active;
    assign bus.mem_we    = (state == DC_WB);
    assign bus.mem_addr  = active ? (cur_base + (WIDTH'(beat_q) << 2)) : '0;
    assign bus.mem_wdata = (state == DC_WB) ? bus.dc_wdata : '0;
    assign bus.ic_rvalid = (state == IC_FILL) && bus.mem_ready;
    assign bus.dc_rvalid = (state == DC_FILL) && bus.mem_ready;
    assign bus.rdata     = ((state == IC_FILL) || (state == DC_FILL)) ? bus.mem_rdata : '0;
    assign bus.beat      = beat_q;
    assign bus.ic_done   = (state == DONE_IC);
    assign bus.dc_done   = (state == DONE_DC);
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fills, dirty write-back, wait states, arbitration, async reset.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   last_dc  = 1'b0;

    mem_arbiter_if #(.WIDTH(32), .LINE_WORDS(4)) bus ();

    mem_arbiter #(.WIDTH(32), .LINE_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit pick_dc(input bit ic, input bit dc);
`ifdef MEM_ARB_RR_EN
        if (ic && dc) return !last_dc;
`endif
        return dc;
    endfunction

    // Called in the first beat cycle of a fill with mem_ready high; returns in the done cycle.
    task automatic run_fill(input bit is_dc, input logic [31:0] base, input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.mem_rdata = 32'hC0DE_0000 + i;
            #1;
            chk({tag, "_addr"}, bus.mem_addr, base + 4 * i);
            chk({tag, "_we"}, bus.mem_we, 0);
            chk({tag, "_beat"}, bus.beat, i);
            chk({tag, "_ic_rv"}, bus.ic_rvalid, !is_dc);
            chk({tag, "_dc_rv"}, bus.dc_rvalid, is_dc);
            chk({tag, "_rdata"}, bus.rdata, 32'hC0DE_0000 + i);
            chk({tag, "_early_done"}, {bus.ic_done, bus.dc_done}, 0);
            tick();
        end
        #1;
        chk({tag, "_ic_done"}, bus.ic_done, !is_dc);
        chk({tag, "_dc_done"}, bus.dc_done, is_dc);
        chk({tag, "_done_busy"}, bus.busy, 1);
        chk({tag, "_done_req"}, bus.mem_req, 0);
    endtask

    initial begin
        logic [31:0] exp_beat [8];
        logic        rdy_pat  [8];
        int          rv_cnt;
        bit          d;

        exp_beat = '{0, 0, 0, 1, 1, 2, 3, 3};
        rdy_pat  = '{0, 0, 1, 0, 1, 1, 0, 1};

        bus.ic_req = 0; bus.ic_addr = 0; bus.dc_req = 0; bus.dc_dirty = 0;
        bus.dc_wb_addr = 0; bus.dc_addr = 0; bus.dc_wdata = 0;
        bus.mem_ready = 0; bus.mem_rdata = 32'h5555_AAAA;

        // Reset state
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_done", {bus.ic_done, bus.dc_done}, 0);
        rst = 0;
        tick();
        chk("idle_busy", bus.busy, 0);

        // Single I-cache fill with mem_ready tied high
        bus.ic_req = 1; bus.ic_addr = 32'h0000_1234; bus.mem_ready = 1;
        #1;
        chk("ic1_grant_req", bus.mem_req, 0);
        tick();
        last_dc = 0;
        run_fill(0, 32'h1230, "ic1");
        bus.ic_req = 0;
        tick();
        #1;
        chk("ic1_after_busy", bus.busy, 0);
        chk("ic1_after_done", bus.ic_done, 0);

        // Dirty D-miss: write-back then fill, done on 10th cycle
        bus.dc_req = 1; bus.dc_dirty = 1; bus.dc_wb_addr = 32'h2000; bus.dc_addr = 32'h3010;
        #1;
        chk("dirty_grant_req", bus.mem_req, 0);
        tick();
        last_dc = 1;
        for (int i = 0; i < 4; i++) begin
            bus.dc_wdata = 32'hBEEF_0000 + i;
            #1;
            chk("wb_addr", bus.mem_addr, 32'h2000 + 4 * i);
            chk("wb_we", bus.mem_we, 1);
            chk("wb_req", bus.mem_req, 1);
            chk("wb_wdata", bus.mem_wdata, 32'hBEEF_0000 + i);
            chk("wb_beat", bus.beat, i);
            chk("wb_rvalid", bus.dc_rvalid, 0);
            tick();
        end
        run_fill(1, 32'h3010, "dfill");
        bus.dc_req = 0; bus.dc_dirty = 0;
        tick();
        #1;
        chk("dirty_after_busy", bus.busy, 0);

        // Simultaneous clean requests
        bus.ic_req = 1; bus.ic_addr = 32'h6000;
        bus.dc_req = 1; bus.dc_addr = 32'h5000;
        tick();
        d = pick_dc(1, 1);
        last_dc = d;
        run_fill(d, d ? 32'h5000 : 32'h6000, "both1");
        if (d) bus.dc_req = 0; else bus.ic_req = 0;
        tick();
        #1;
        chk("both_idle_req", bus.mem_req, 0);
        chk("both_idle_busy", bus.busy, 0);
        tick();
        last_dc = !d;
        run_fill(!d, d ? 32'h6000 : 32'h5000, "both2");
        bus.dc_req = 0; bus.ic_req = 0;
        tick();

        // Wait states: mem_ready already high during grant must not advance the beat
        bus.ic_req = 1; bus.ic_addr = 32'h4008; bus.mem_ready = 1;
        tick();
        last_dc = 0;
        rv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = rdy_pat[i];
            #1;
            chk("ws_beat", bus.beat, exp_beat[i]);
            chk("ws_addr", bus.mem_addr, 32'h4000 + 4 * exp_beat[i]);
            chk("ws_req", bus.mem_req, 1);
            chk("ws_rvalid", bus.ic_rvalid, rdy_pat[i]);
            if (bus.ic_rvalid) rv_cnt++;
            tick();
        end
        chk("ws_rv_count", rv_cnt, 4);
        #1;
        chk("ws_done", bus.ic_done, 1);
        bus.ic_req = 0; bus.mem_ready = 1;
        tick();

        // Starvation / round-robin: D held high for three services while I waits
        bus.ic_req = 1; bus.ic_addr = 32'h8000;
        bus.dc_req = 1; bus.dc_addr = 32'h7000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stv_idle", bus.busy, 0);
            tick();
            d = pick_dc(1, 1);
            last_dc = d;
            run_fill(d, d ? 32'h7000 : 32'h8000, "stv");
            if (k == 2) bus.dc_req = 0;
            tick();
        end
        tick();
        d = pick_dc(1, 0);
        last_dc = d;
        run_fill(d, 32'h8000, "stv_last");
        bus.ic_req = 0;
        tick();

        // Asynchronous reset during beat 2 of a fill
        bus.ic_req = 1; bus.ic_addr = 32'h9000;
        tick();
        tick();
        tick();
        #1;
        chk("mid_beat", bus.beat, 2);
        rst = 1;
        #1;
        chk("arst_req", bus.mem_req, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_rvalid", bus.ic_rvalid, 0);
        chk("arst_addr", bus.mem_addr, 0);
        chk("arst_beat", bus.beat, 0);
        bus.ic_req = 0;
        tick();
        rst = 0;
        last_dc = 0;
        #1;
        chk("post_rst_done", bus.ic_done, 0);
        chk("post_rst_busy", bus.busy, 0);
        bus.ic_req = 1; bus.ic_addr = 32'hA004;
        tick();
        run_fill(0, 32'hA000, "restart");
        bus.ic_req = 0;
        tick();
        #1;
        chk("end_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between I-cache and D-cache line refills, plus D-cache dirty-line write-back.
- Sequences each line as LINE_WORDS single-word beats.
- Returns fill data to the owning cache and signals completion.
- Sits below both caches; the caches derive cache_stall (freezing the pipeline registers) from their outstanding request until done.

Parameters:
- WIDTH, 32: data/address width.
- LINE_WORDS, 4: words per cache line; power of two, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ic_req  in  1  I-cache refill request; held high until ic_done
- ic_addr  in  WIDTH  I-cache line byte address; offset bits ignored
- dc_req  in  1  D-cache request; held high until dc_done
- dc_dirty  in  1  victim line dirty; write-back precedes fill
- dc_wb_addr  in  WIDTH  victim line byte address
- dc_addr  in  WIDTH  D-cache fill line byte address
- dc_wdata  in  WIDTH  write-back word for beat dc_beat (combinational from cache)
- ic_rvalid  out  1  fill word valid to I-cache
- dc_rvalid  out  1  fill word valid to D-cache
- rdata  out  WIDTH  fill word (mem_rdata forwarded)
- beat  out  log2(LINE_WORDS)  current beat index
- ic_done  out  1  one-cycle pulse: I-cache line complete
- dc_done  out  1  one-cycle pulse: D-cache transaction complete
- busy  out  1  state != IDLE
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = write beat
- mem_addr  out  WIDTH  beat byte address
- mem_wdata  out  WIDTH  write data
- mem_ready  in  1  beat accepted/completed this cycle
- mem_rdata  in  WIDTH  read data, valid when mem_ready on a read beat

Behaviour:
- States:
  - IDLE
  - IC_FILL
  - DC_WB
  - DC_FILL
  - DONE_IC
  - DONE_DC
- Reset (any time, including mid-burst): state=IDLE, beat counter=0, last-grant=IC, all outputs 0.
- A partially completed burst is abandoned.
- Arbitration occurs only in IDLE.
  - dc_req has fixed priority over ic_req (default build).
  - dc_req && dc_dirty -> DC_WB.
  - dc_req && !dc_dirty -> DC_FILL.
  - else ic_req -> IC_FILL.
- Addresses are latched on grant.
- Line base = addr with low log2(LINE_WORDS)+2 bits cleared.
- mem_addr = base + beat*4.
- Grant sampled at edge t; mem_req=1 from cycle t+1.
- In IC_FILL, DC_WB and DC_FILL:
  - mem_req=1 every cycle.
  - A beat completes in the cycle mem_ready=1.
  - The counter increments on each completed beat and wraps to 0 after the last beat.
- DC_WB:
  - mem_we=1, mem_wdata=dc_wdata, dc_beat=beat.
  - After the last beat -> DC_FILL with counter 0 and no idle cycle.
- Fill states:
  - mem_we=0.
  - ic_rvalid or dc_rvalid = mem_ready; rdata=mem_rdata; beat identifies the word.
  - After the last beat -> DONE_IC or DONE_DC.
- DONE_x:
  - Corresponding done=1 for exactly one cycle, then IDLE.
  - A request still high during DONE is never re-granted, because arbitration is IDLE-only.
- A request deasserted mid-service (protocol violation) does not abort the burst.
- mem_ready while mem_req=0 is ignored.
- Minimum transaction time with mem_ready tied high:
  - Clean fill: 1 + LINE_WORDS + 1 cycles (grant, beats, done).
  - Dirty: 1 + 2*LINE_WORDS + 1 cycles.
- busy=1 in all non-IDLE states.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin between caches.
  - In IDLE, with both requests pending, grant goes to the cache not served last.
  - last-grant is updated on each grant.
  - A single pending request is granted immediately.
- MEM_ARB_RR_EN undefined: fixed D-cache priority; the I-cache can starve under back-to-back D misses.

Test Plan:
- Reset, idle: all outputs 0, busy=0. ic_req=1, ic_addr=0x0000_1234, mem_ready=1 -> mem_addr 0x1230,0x1234,0x1238,0x123C on consecutive cycles. ic_rvalid=1 with beat 0..3, then ic_done one cycle, then busy=0.
- Dirty D-miss: dc_req=1, dc_dirty=1, dc_wb_addr=0x2000, dc_addr=0x3010.
  - Write beats first: mem_we=1 at 0x2000..0x200C, with mem_wdata tracking dc_wdata per dc_beat.
  - Then read beats: mem_we=0 at 0x3010..0x301C.
  - dc_done after 10 cycles total.
- Wait states: mem_ready pattern 0,0,1,0,1,1,0,1 -> beat advances only on ready cycles. mem_addr holds during stalls; exactly 4 rvalid pulses.
- Simultaneous ic_req and dc_req (clean):
  - Default: D served first, I granted in the IDLE following DONE_DC.
  - With MEM_ARB_RR_EN and last-grant=DC: I served first.
- Starvation/RR: dc_req reasserted immediately after each dc_done for 3 lines while ic_req stays high.
  - Default: I never granted.
  - With MEM_ARB_RR_EN: service alternates D,I,D,I.
- rst pulsed during beat 2 of a fill: outputs 0 immediately (asynchronous). After release, a fresh request restarts at beat 0 with no stale done pulse.
